operand_serializer: RTL and testbench

- Upstream feeder for the compute stage's input shifter. Runs in the source ("prev") clock domain.
- Accepts one operand pair (A, B) plus an ALU control code over a valid/ready handshake.
- Serializes the 16-bit word {A,B} MSB-first as a serial bit plus a per-bit shift strobe.
- Then waits for the downstream shifter's "data valid" acknowledge before accepting the next pair. Flags a timeout if the acknowledge never arrives.

---
 rtl/cdc_pkg.sv | 15 +
 rtl/operand_serializer_ack_timer.sv | 31 +++
 rtl/operand_serializer.sv | 128 ++++++++++++
 tb/tb_operand_serializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Types and constants shared by the operand serializer and the compute stage.
package cdc_pkg;

    localparam int DATA_WIDTH = 8;

    typedef logic [2:0] ctl_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } ser_state_t;

endpackage

// File: rtl/operand_serializer_ack_timer.sv
// Saturating counter with clear and enable; expire marks the enabled cycle that
// completes LIMIT counted cycles.
module ack_timer #(
    parameter int LIMIT = 15,
    parameter int W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] TOP  = W'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != TOP) begin
            count <= count + 1'b1;
        end
    end

    assign expire = en & (count == LAST);

endmodule

// File: rtl/operand_serializer.sv
// Serializes {A,B} MSB-first with a per-bit strobe, then waits for the downstream
// shifter's acknowledge; a missing acknowledge sets a sticky error.
module operand_serializer
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH  = cdc_pkg::DATA_WIDTH,
    parameter int WORD_WIDTH  = 2 * DATA_WIDTH,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  ctl_t                  ctl_i,
    output ctl_t                  ctl_o,
    output logic                  shift_o,
    output logic                  serial_o,
    input  logic                  done_i,
    output logic                  frame_done_o,
    output logic                  busy_o,
    output logic                  err_o,
    output ser_state_t            state_o
);

    localparam int CNT_W = $clog2(WORD_WIDTH + 1);

    ser_state_t            state;
    ser_state_t            state_nxt;
    logic [WORD_WIDTH-1:0] sreg;
    logic [CNT_W-1:0]      cnt;
    logic                  accept;
    logic                  timer_clr;
    logic                  timer_en;
    logic                  expire;

    // valid/ready: a pair transfers on an edge where valid_i and the registered
    // ready_o are both high. ready_o is honoured even if en_i just dropped, so
    // the upstream never loses a pair it believes was taken.
    assign accept    = (state == IDLE) & valid_i & ready_o;
    assign timer_clr = (state != WAIT_ACK);
    assign timer_en  = (state == WAIT_ACK) & en_i;
    assign state_o   = state;

    ack_timer #(
        .LIMIT (ACK_TIMEOUT),
        .W     (8)
    ) u_ack_timer (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .clr    (timer_clr),
        .en     (timer_en),
        .expire (expire)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (en_i && cnt == '0) state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                // An acknowledge on the timeout edge still counts as success.
                if (en_i && done_i) state_nxt = DONE;
                else if (expire)    state_nxt = IDLE;
            end
            DONE: begin
                if (en_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            sreg         <= '0;
            cnt          <= '0;
            ready_o      <= 1'b0;
            ctl_o        <= '0;
            shift_o      <= 1'b0;
            serial_o     <= 1'b0;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state        <= state_nxt;
            ready_o      <= (state_nxt == IDLE) & en_i;
            busy_o       <= (state_nxt != IDLE);
            frame_done_o <= (state == WAIT_ACK) & (state_nxt == DONE);
            shift_o      <= 1'b0;
            if (expire && !done_i) err_o <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        ctl_o <= ctl_i;
                        // The first bit leaves on the accept edge itself.
                        if (en_i) begin
                            shift_o  <= 1'b1;
                            serial_o <= a_i[DATA_WIDTH-1];
                            sreg     <= {a_i[DATA_WIDTH-2:0], b_i, 1'b0};
                            cnt      <= CNT_W'(WORD_WIDTH - 1);
                        end else begin
                            sreg <= {a_i, b_i};
                            cnt  <= CNT_W'(WORD_WIDTH);
                        end
                    end
                end
                SHIFT: begin
                    if (en_i && cnt != '0) begin
                        shift_o  <= 1'b1;
                        serial_o <= sreg[WORD_WIDTH-1];
                        sreg     <= {sreg[WORD_WIDTH-2:0], 1'b0};
                        cnt      <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_serializer.sv
// Directed bench for operand_serializer: table of frames plus hand-written
// pause, timeout, back-to-back and mid-frame reset sequences.
module tb_operand_serializer;
    import cdc_pkg::*;

    localparam int WW = 16;

    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b0;
    logic       en_i    = 1'b0;
    logic       valid_i = 1'b0;
    logic       done_i  = 1'b0;
    logic [7:0] a_i     = '0;
    logic [7:0] b_i     = '0;
    ctl_t       ctl_i   = '0;
    logic       ready_o;
    logic       shift_o;
    logic       serial_o;
    logic       frame_done_o;
    logic       busy_o;
    logic       err_o;
    ctl_t       ctl_o;
    ser_state_t state_o;

    int tests  = 0;
    int fails  = 0;
    int cyc_now = 0;
    logic [WW-1:0] exp_q[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  ctl;
        int          ack_delay;
        logic [15:0] exp_word;
    } vec_t;

    vec_t vecs[5];

    operand_serializer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .a_i          (a_i),
        .b_i          (b_i),
        .ctl_i        (ctl_i),
        .ctl_o        (ctl_o),
        .shift_o      (shift_o),
        .serial_o     (serial_o),
        .done_i       (done_i),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc_now);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc_now++;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] ctl,
                        input logic [15:0] exp_word, output int t_acc);
        a_i = a;
        b_i = b;
        ctl_i = ctl;
        valid_i = 1'b1;
        exp_q.push_back(exp_word);
        for (int w = 0; w < 64 && !ready_o; w++) step();
        chk("ready_wait", ready_o, 1);
        step();
        valid_i = 1'b0;
        t_acc = cyc_now;
        chk("ready_after_accept", ready_o, 0);
        chk("busy_after_accept", busy_o, 1);
        chk("ctl_capture", ctl_o, ctl);
    endtask

    task automatic collect(input int pause_after, input int pause_len, input int t_acc);
        logic [15:0] word;
        logic [15:0] exp;
        int n;
        int gaps;
        int pcnt;
        int t_first;
        word = '0;
        n = 0;
        gaps = 0;
        pcnt = 0;
        t_first = -1;
        for (int c = 0; c < 80; c++) begin
            if (shift_o) begin
                if (n == 0) t_first = cyc_now;
                word = {word[14:0], serial_o};
                n++;
                if (n == pause_after) pcnt = pause_len;
            end else begin
                gaps++;
                chk("serial_hold", serial_o, word[0]);
            end
            if (n == 16) break;
            if (pcnt > 0) begin
                en_i = 1'b0;
                pcnt--;
            end else begin
                en_i = 1'b1;
            end
            step();
        end
        en_i = 1'b1;
        chk("strobe_count", n, 16);
        chk("first_strobe", t_first, t_acc);
        chk("pause_gaps", gaps, pause_len);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk("serial_word", word, exp);
        step();
        chk("shift_after_frame", shift_o, 0);
        chk("busy_wait_ack", busy_o, 1);
    endtask

    task automatic ack(input int delay);
        for (int i = 0; i < delay; i++) begin
            chk("no_early_frame_done", frame_done_o, 0);
            step();
        end
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        chk("frame_done_pulse", frame_done_o, 1);
        chk("ready_during_done", ready_o, 0);
        step();
        chk("frame_done_single", frame_done_o, 0);
        chk("ready_after_done", ready_o, 1);
        chk("busy_after_done", busy_o, 0);
    endtask

    initial begin
        int t_acc;
        int t_acc2;

        vecs[0] = '{8'hA5, 8'h3C, 3'b010, 1, 16'hA53C};
        vecs[1] = '{8'hFF, 8'h00, 3'b111, 0, 16'hFF00};
        vecs[2] = '{8'h00, 8'hFF, 3'b001, 2, 16'h00FF};
        vecs[3] = '{8'h81, 8'h7E, 3'b100, 4, 16'h817E};
        vecs[4] = '{8'h12, 8'h34, 3'b011, 1, 16'h1234};

        // Reset held with en_i high.
        en_i = 1'b1;
        rst_i = 1'b0;
        step();
        step();
        step();
        chk("rst_ready", ready_o, 0);
        chk("rst_shift", shift_o, 0);
        chk("rst_serial", serial_o, 0);
        chk("rst_ctl", ctl_o, 0);
        chk("rst_frame_done", frame_done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        rst_i = 1'b1;
        chk("ready_before_edge", ready_o, 0);
        step();
        chk("ready_first_edge", ready_o, 1);

        // Table of ordinary frames.
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].ctl, vecs[i].exp_word, t_acc);
            collect(0, 0, t_acc);
            ack(vecs[i].ack_delay);
            chk("ctl_hold", ctl_o, vecs[i].ctl);
        end

        // Enable paused for 3 cycles after the 5th strobe.
        send(8'hA5, 8'h3C, 3'b010, 16'hA53C, t_acc);
        collect(5, 3, t_acc);
        ack(1);

        // Back-to-back pairs with valid_i held; minimum period.
        send(8'hFF, 8'h00, 3'b110, 16'hFF00, t_acc);
        a_i = 8'h01;
        b_i = 8'h80;
        ctl_i = 3'b001;
        valid_i = 1'b1;
        collect(0, 0, t_acc);
        chk("ctl_held_while_busy", ctl_o, 3'b110);
        ack(0);
        chk("ctl_held_until_accept", ctl_o, 3'b110);
        send(8'h01, 8'h80, 3'b001, 16'h0180, t_acc2);
        chk("frame_period", t_acc2 - t_acc, 19);
        collect(0, 0, t_acc2);
        ack(1);

        // Acknowledge never arrives; two disabled cycles at the start of the wait.
        send(8'h5A, 8'hC3, 3'b101, 16'h5AC3, t_acc);
        collect(0, 0, t_acc);
        chk("err_before_timeout", err_o, 0);
        en_i = 1'b0;
        step();
        step();
        en_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            chk("err_early", err_o, 0);
            chk("timeout_no_frame_done", frame_done_o, 0);
        end
        step();
        chk("err_at_timeout", err_o, 1);
        chk("timeout_frame_done", frame_done_o, 0);
        chk("timeout_busy", busy_o, 0);
        chk("timeout_ready", ready_o, 1);
        send(8'h3C, 8'hA5, 3'b011, 16'h3CA5, t_acc);
        collect(0, 0, t_acc);
        ack(2);
        chk("err_sticky", err_o, 1);

        // Reset pulse after 8 strobes aborts the frame.
        send(8'hC3, 8'h5A, 3'b111, 16'hC35A, t_acc);
        for (int i = 0; i < 8; i++) begin
            chk("pre_reset_strobe", shift_o, 1);
            if (i < 7) step();
        end
        #2;
        rst_i = 1'b0;
        #1;
        chk("async_reset_shift", shift_o, 0);
        chk("async_reset_busy", busy_o, 0);
        chk("async_reset_ready", ready_o, 0);
        chk("async_reset_err", err_o, 0);
        void'(exp_q.pop_back());
        step();
        chk("reset_no_frame_done", frame_done_o, 0);
        step();
        rst_i = 1'b1;
        step();
        chk("ready_after_reset", ready_o, 1);
        chk("no_frame_done_after_reset", frame_done_o, 0);
        send(8'h96, 8'h69, 3'b100, 16'h9669, t_acc);
        collect(0, 0, t_acc);
        ack(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
